seven_segment_capture: RTL and testbench
========================================

// Module: seven_segment_capture
// PURPOSE
//   Receive-side counterpart of the multiplexed seven-segment display driver.
//   Samples the scanned DIGIT/DISPLAY bus, which is produced in another clock
//   domain, and decodes each segment pattern back to BCD.
//   Assembles complete 4-digit frames and flags invalid patterns and a stalled scan.
//   Used on-board for loopback self-check of display paths and by benches as a scan monitor.
// PARAMETERS
//   STABLE_CYCLES   4        consecutive identical samples required before a digit is accepted (>=2)
//   TIMEOUT_CYCLES  1048576  clk cycles without a completed frame before stale asserts
// PORTS
//   clk          in   1   system clock; all logic on rising edge
//   reset        in   1   asynchronous, active-low reset
//   DIGIT        in   4   anode select, active-low; DIGIT[i]=0 selects position i
//   DISPLAY      in   7   segments, active-low, {g,f,e,d,c,b,a}
//   value        out  16  last complete frame {BCD3,BCD2,BCD1,BCD0}; BCDi decoded at DIGIT[i]
//   digit_err    out  4   per-position invalid-pattern flag for the frame in value
//   frame_valid  out  1   one-cycle pulse on the cycle value/digit_err update
//   stale        out  1   high when no frame has completed for TIMEOUT_CYCLES
// BEHAVIOUR
//   Reset (reset=0, async): value=16'h0000, digit_err=4'h0, frame_valid=0, stale=1.
//   Reset also sets: synchronizer flops to all-ones (idle bus), FSM=HUNT, staging and seen mask cleared.
//   Input sync: {DIGIT,DISPLAY} pass through a 2-flop synchronizer; all logic uses the synced copy S.
//   Stability: cnt clears whenever S differs from its previous-cycle value, otherwise increments (saturating).
//   FSM:
//     HUNT   : S.DIGIT not exactly one-hot-low (all-ones, multi-low) -> stay; one-hot -> SETTLE.
//     SETTLE : S changes -> recount; S.DIGIT leaves one-hot -> HUNT;
//              S unchanged for STABLE_CYCLES consecutive edges -> capture, -> HOLD.
//     HOLD   : wait until S.DIGIT changes -> SETTLE if one-hot, else HUNT.
//              Exactly one capture per scan dwell.
//   Capture: decode S.DISPLAY into stage[i] and err_stage[i]; set seen[i]. Recapture of a seen i overwrites it.
//   Decode (active-low):
//     0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//     5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//     1111111 (blank) -> nibble 4'hF, err 0; any other pattern -> nibble 4'hE, err 1.
//   Frame: on the edge after seen becomes 4'hF:
//     value <= stage, digit_err <= err_stage, frame_valid=1 for that cycle;
//     seen cleared same edge; stale <= 0. value/digit_err never change otherwise.
//   Latency: DIGIT/DISPLAY change -> capture = 2 (sync) + STABLE_CYCLES edges; capture -> frame_valid = 1 edge.
//   Stale: tcnt clears on frame_valid, else increments (saturating); stale <= 1 when tcnt reaches TIMEOUT_CYCLES-1.
//     frame completion and timeout on the same edge -> frame wins, stale=0.
//   Glitch shorter than STABLE_CYCLES: no capture, no state other than cnt affected.
//   Reset mid-frame: partial staging discarded; value returns to 0.
// TESTING
//   Scan 1,2,3,4 on DIGIT[3:0], 16 clk dwell each, STABLE_CYCLES=4
//     -> value=16'h1234, digit_err=0, one frame_valid pulse per full scan, stale=0.
//   DIGIT[2] shows 0101010, others valid "0"
//     -> value=16'h0E00, digit_err=4'b0100.
//   2-cycle segment glitch inside a dwell of digit 7
//     -> single capture, BCD=7, no extra frame_valid.
//   DIGIT=4'b0011 (two low) held 20 cycles -> FSM stays in HUNT, no capture, seen unchanged.
//   Stop scanning after one frame, TIMEOUT_CYCLES=64 -> stale rises 64 edges after frame_valid;
//     resume scan -> stale falls with next frame_valid.
//   Assert reset after 3 of 4 digits captured -> all outputs at reset values;
//     next full scan yields one correct frame.

Source files
------------

// File: rtl/seven_segment_capture.sv
// seven_segment_capture
//   Receive side of a multiplexed seven-segment display bus. The scanned
//   DIGIT/DISPLAY bus comes from another clock domain: it is synchronised,
//   each digit dwell is captured once after it has settled, and the segment
//   pattern is decoded back to BCD. Complete 4-digit frames are published on
//   value/digit_err, and stale flags a scan that has stopped producing frames.
//
// Ports
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   DIGIT        in   4   anode select, active-low; DIGIT[i]=0 selects position i
//   DISPLAY      in   7   segments, active-low, {g,f,e,d,c,b,a}
//   value        out  16  last complete frame {BCD3,BCD2,BCD1,BCD0}
//   digit_err    out  4   per-position invalid-pattern flags for value
//   frame_valid  out  1   one-cycle pulse when value/digit_err update
//   stale        out  1   no frame completed for TIMEOUT_CYCLES cycles
module seven_segment_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  DIGIT,
  input  logic [6:0]  DISPLAY,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  // cnt lags the run of identical samples by two: one for the edge that saw
  // the change, one for the equality seen on the capturing edge itself.
  localparam logic [CW-1:0] CNT_CAP  = CW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {HUNT, SETTLE, HOLD} state_t;

  // Returns {err, nibble} for an active-low segment pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = {1'b0, 4'h0};
      7'b1111001: r = {1'b0, 4'h1};
      7'b0100100: r = {1'b0, 4'h2};
      7'b0110000: r = {1'b0, 4'h3};
      7'b0011001: r = {1'b0, 4'h4};
      7'b0010010: r = {1'b0, 4'h5};
      7'b0000010: r = {1'b0, 4'h6};
      7'b1111000: r = {1'b0, 4'h7};
      7'b0000000: r = {1'b0, 4'h8};
      7'b0010000: r = {1'b0, 4'h9};
      7'b1111111: r = {1'b0, 4'hF};
      default:    r = {1'b1, 4'hE};
    endcase
    return r;
  endfunction

  logic [10:0]   r_sync_p0, r_sync_p1, r_prev;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic [15:0]   r_stage;
  logic [3:0]    r_err_stage, r_seen;
  logic [15:0]   r_value;
  logic [3:0]    r_digit_err;
  logic          r_frame_valid, r_stale;
  logic [TW-1:0] r_tcnt;

  logic [3:0] w_sel;
  logic       w_onehot, w_same, w_dig_chg, w_cap, w_frame;
  logic [4:0] w_dec;

  // Synchroniser stages; idle bus (all ones) out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_p0 <= '1;
      r_sync_p1 <= '1;
      r_prev    <= '1;
    end else begin
      r_sync_p0 <= {DIGIT, DISPLAY};
      r_sync_p1 <= r_sync_p0;
      r_prev    <= r_sync_p1;
    end
  end

  // Synced-sample qualification
  assign w_sel     = ~r_sync_p1[10:7];
  assign w_onehot  = (w_sel != 4'd0) && ((w_sel & (w_sel - 4'd1)) == 4'd0);
  assign w_same    = (r_sync_p1 == r_prev);
  assign w_dig_chg = (r_sync_p1[10:7] != r_prev[10:7]);
  assign w_cap     = (r_state == SETTLE) && w_onehot && w_same && (r_cnt >= CNT_CAP);
  assign w_dec     = decode_seg(r_sync_p1[6:0]);
  assign w_frame   = (r_seen == 4'hF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!w_same) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Dwell tracking: HOLD blocks further captures until DIGIT moves on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= HUNT;
    end else begin
      case (r_state)
        HUNT:    if (w_onehot) r_state <= SETTLE;
        SETTLE:  if (!w_onehot) r_state <= HUNT;
                 else if (w_cap) r_state <= HOLD;
        HOLD:    if (w_dig_chg) r_state <= w_onehot ? SETTLE : HUNT;
        default: r_state <= HUNT;
      endcase
    end
  end

  // Capture staging and frame publication
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stage       <= '0;
      r_err_stage   <= '0;
      r_seen        <= '0;
      r_value       <= '0;
      r_digit_err   <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_frame;
      if (w_frame) begin
        r_value     <= r_stage;
        r_digit_err <= r_err_stage;
      end
      for (int i = 0; i < 4; i++) begin
        if (w_cap && w_sel[i]) begin
          r_stage[i*4 +: 4] <= w_dec[3:0];
          r_err_stage[i]    <= w_dec[4];
        end
      end
      // A capture landing on the publishing edge starts the next frame.
      r_seen <= (w_frame ? 4'h0 : r_seen) | (w_cap ? w_sel : 4'h0);
    end
  end

  // Stall detection; a completing frame overrides a same-edge timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt  <= '0;
      r_stale <= 1'b1;
    end else if (w_frame) begin
      r_tcnt  <= '0;
      r_stale <= 1'b0;
    end else if (r_tcnt == TCNT_MAX) begin
      r_stale <= 1'b1;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign value       = r_value;
  assign digit_err   = r_digit_err;
  assign frame_valid = r_frame_valid;
  assign stale       = r_stale;

endmodule

// File: tb/tb_seven_segment_capture.sv
module tb_seven_segment_capture;

  localparam int SC = 4;
  localparam int TO = 64;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  DIGIT = 4'hF;
  logic [6:0]  DISPLAY = 7'h7F;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        stale;

  seven_segment_capture #(.STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .DIGIT(DIGIT), .DISPLAY(DISPLAY),
    .value(value), .digit_err(digit_err), .frame_valid(frame_valid), .stale(stale)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fv_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: the synced stream is the input delayed two edges; a
  // digit is taken the first time inside a DIGIT dwell that the stream has
  // held one value for SC samples; a full set of four publishes next edge.
  function automatic logic [4:0] model_dec(input logic [6:0] p);
    if (p == 7'h7F) return {1'b0, 4'hF};
    for (int k = 0; k < 10; k++) if (SEG_TAB[k] == p) return {1'b0, 4'(k)};
    return {1'b1, 4'hE};
  endfunction

  logic [10:0] m_s1 = '1;
  logic [10:0] m_hist [$];
  int          m_dwell = 0, m_cap_dwell = -1, m_since = TO;
  logic [15:0] m_stage = '0, e_value = '0;
  logic [3:0]  m_err_stage = '0, m_seen = '0, e_err = '0;
  logic        e_fv = 1'b0, e_stale = 1'b1;
  logic [10:0] m_cur;
  logic [3:0]  m_sel;
  logic [4:0]  m_d;
  int          m_run;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = '1;
      m_hist = {};
      m_hist.push_back('1);
      m_hist.push_back('1);
      m_dwell = 0; m_cap_dwell = -1; m_since = TO;
      m_stage = '0; m_err_stage = '0; m_seen = '0;
      e_value = '0; e_err = '0; e_fv = 1'b0; e_stale = 1'b1;
    end else begin
      m_cur = m_hist[$];
      m_run = 0;
      for (int k = m_hist.size() - 1; k >= 0; k--) begin
        if (m_hist[k] == m_cur) m_run++;
        else break;
      end
      m_sel = ~m_cur[10:7];
      e_fv = 1'b0;
      if (m_seen == 4'hF) begin
        e_value = m_stage; e_err = m_err_stage; e_fv = 1'b1;
        m_seen = 4'h0; m_since = 0;
      end else if (m_since < TO) begin
        m_since++;
      end
      e_stale = (m_since >= TO);
      if ($countones(m_sel) == 1 && m_run >= SC && m_cap_dwell != m_dwell) begin
        m_d = model_dec(m_cur[6:0]);
        for (int i = 0; i < 4; i++) begin
          if (m_sel[i]) begin
            m_stage[i*4 +: 4] = m_d[3:0];
            m_err_stage[i] = m_d[4];
            m_seen[i] = 1'b1;
          end
        end
        m_cap_dwell = m_dwell;
      end
      if (m_s1[10:7] != m_cur[10:7]) m_dwell++;
      m_hist.push_back(m_s1);
      if (m_hist.size() > 16) void'(m_hist.pop_front());
      m_s1 = {DIGIT, DISPLAY};
    end
  end

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (reset) begin
      check("value", 32'(value), 32'(e_value));
      check("digit_err", 32'(digit_err), 32'(e_err));
      check("frame_valid", 32'(frame_valid), 32'(e_fv));
      check("stale", 32'(stale), 32'(e_stale));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dwell(input logic [3:0] dig, input logic [6:0] seg, input int cyc);
    DIGIT = dig; DISPLAY = seg;
    tick(cyc);
  endtask

  task automatic scan(input logic [6:0] p3, input logic [6:0] p2,
                      input logic [6:0] p1, input logic [6:0] p0, input int cyc);
    dwell(4'b1110, p0, cyc);
    dwell(4'b1101, p1, cyc);
    dwell(4'b1011, p2, cyc);
    dwell(4'b0111, p3, cyc);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_value"}, 32'(value), 32'h0);
    check({tag, "_err"}, 32'(digit_err), 32'h0);
    check({tag, "_fv"}, 32'(frame_valid), 32'h0);
    check({tag, "_stale"}, 32'(stale), 32'h1);
  endtask

  int fv0;
  logic [3:0] rd;
  logic [6:0] rs;
  int rc, gpos;

  initial begin
    tick(3);
    check_reset_vals("rst");
    reset = 1'b1;
    tick(2);

    // Three scans of 1,2,3,4
    fv0 = fv_cnt;
    repeat (3) scan(SEG_TAB[1], SEG_TAB[2], SEG_TAB[3], SEG_TAB[4], 16);
    check("scan_value", 32'(value), 32'h1234);
    check("scan_err", 32'(digit_err), 32'h0);
    check("scan_stale", 32'(stale), 32'h0);
    check("scan_frames", 32'(fv_cnt - fv0), 32'd3);

    // Invalid pattern at position 2
    scan(SEG_TAB[0], 7'b0101010, SEG_TAB[0], SEG_TAB[0], 16);
    check("bad_value", 32'(value), 32'h0E00);
    check("bad_err", 32'(digit_err), 32'h4);

    // Segment glitch early in the dwell of a 7 at position 1
    fv0 = fv_cnt;
    dwell(4'b1110, SEG_TAB[0], 16);
    DIGIT = 4'b1101; DISPLAY = SEG_TAB[7];
    tick(3);
    DISPLAY = SEG_TAB[8];
    tick(2);
    DISPLAY = SEG_TAB[7];
    tick(11);
    dwell(4'b1011, SEG_TAB[0], 16);
    dwell(4'b0111, SEG_TAB[0], 16);
    check("glitch_value", 32'(value), 32'h0070);
    check("glitch_frames", 32'(fv_cnt - fv0), 32'd1);

    // Two anodes low: ignored, partial frame survives
    fv0 = fv_cnt;
    dwell(4'b1110, SEG_TAB[5], 16);
    dwell(4'b1101, SEG_TAB[6], 16);
    dwell(4'b0011, SEG_TAB[8], 20);
    check("multilow_frames", 32'(fv_cnt - fv0), 32'd0);
    dwell(4'b1011, SEG_TAB[9], 16);
    dwell(4'b0111, SEG_TAB[2], 16);
    check("multilow_value", 32'(value), 32'h2965);
    check("multilow_count", 32'(fv_cnt - fv0), 32'd1);

    // Scan stops, then resumes
    dwell(4'hF, 7'h7F, 40);
    check("stale_early", 32'(stale), 32'h0);
    tick(30);
    check("stale_late", 32'(stale), 32'h1);
    scan(SEG_TAB[1], SEG_TAB[2], SEG_TAB[3], SEG_TAB[4], 16);
    check("stale_resume", 32'(stale), 32'h0);
    check("resume_value", 32'(value), 32'h1234);

    // Reset with three of four digits captured
    dwell(4'b1110, SEG_TAB[9], 16);
    dwell(4'b1101, SEG_TAB[8], 16);
    dwell(4'b1011, SEG_TAB[7], 16);
    reset = 1'b0; DIGIT = 4'hF; DISPLAY = 7'h7F;
    tick(1);
    check_reset_vals("midrst");
    tick(2);
    reset = 1'b1;
    fv0 = fv_cnt;
    scan(SEG_TAB[3], SEG_TAB[4], SEG_TAB[5], SEG_TAB[6], 16);
    check("postrst_value", 32'(value), 32'h3456);
    check("postrst_frames", 32'(fv_cnt - fv0), 32'd1);

    // Randomised scanning checked by the model each cycle
    for (int it = 0; it < 200; it++) begin
      rd = ($urandom_range(0, 9) < 8) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      rc = $urandom_range(0, 19);
      rs = (rc < 14) ? SEG_TAB[$urandom_range(0, 9)] : (rc < 17) ? 7'h7F : 7'($urandom);
      rc = $urandom_range(2, 20);
      DIGIT = rd; DISPLAY = rs;
      if ($urandom_range(0, 4) == 0 && rc > 6) begin
        gpos = $urandom_range(1, rc - 4);
        tick(gpos);
        DISPLAY = 7'($urandom);
        tick($urandom_range(1, 2));
        DISPLAY = rs;
        tick(3);
      end else begin
        tick(rc);
      end
    end
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
